bram_mem_rsp: RTL and testbench

Memory-side responder for the backup-RAM cartridge bus used by the Mega-CD mapper. It consumes the level-style request strobes (`oe`, `we_lo`, `we_hi`) that the RAM-cart logic drives on its memory bus and turns each request edge into a timed cycle on the external asynchronous SRAM. It returns registered read data and serializes overlapping requests. It sits between the mapper's `bram` MemBus and the board SRAM pins, in the same clock domain as the mapper.

---
 rtl/bram_rsp_pkg.sv | 24 ++
 rtl/bram_mem_rsp.sv | 161 ++++++++++++++++
 tb/tb_bram_mem_rsp.sv | 360 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/bram_rsp_pkg.sv
// Shared types and default timing for the backup-RAM SRAM responder.
package bram_rsp_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2,
    REC  = 2'd3
  } rsp_state_t;

  localparam int RD_CYC_DEF = 4;
  localparam int WR_CYC_DEF = 4;
  localparam int ADDR_W_DEF = 18;

  // Pending write record. The address field is sized for the default bus
  // width; the responder casts to and from its own ADDR_W.
  typedef struct packed {
    logic [ADDR_W_DEF-1:0] addr;
    logic [15:0]           data;
    logic [1:0]            mask;   // {hi lane, lo lane}
    logic                  valid;
  } pend_t;

endpackage

// File: rtl/bram_mem_rsp.sv
// Turns level-style read/write strobes from the mapper's memory bus into
// timed cycles on an asynchronous 16-bit SRAM, one cycle at a time.
module bram_mem_rsp
  import bram_rsp_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int RD_CYC = RD_CYC_DEF,
  parameter int WR_CYC = WR_CYC_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [15:0]       mem_din,
  input  logic              mem_oe,
  input  logic              mem_we_lo,
  input  logic              mem_we_hi,
  output logic [15:0]       mem_dout,
  output logic              busy,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [15:0]       sram_dq_o,
  output logic              sram_dq_oe,
  input  logic [15:0]       sram_dq_i,
  output logic              sram_ce_n,
  output logic              sram_oe_n,
  output logic              sram_we_n,
  output logic              sram_lb_n,
  output logic              sram_ub_n
);

  localparam int MAX_CYC = (RD_CYC > WR_CYC) ? RD_CYC : WR_CYC;
  localparam int CW      = $clog2(MAX_CYC) + 1;
  localparam logic [CW-1:0] RD_LOAD = CW'(RD_CYC - 1);
  localparam logic [CW-1:0] WR_LOAD = CW'(WR_CYC - 1);

  rsp_state_t        state_reg;
  logic [CW-1:0]     cnt_reg;
  logic              oe_prev_reg;
  logic              we_prev_reg;
  logic [ADDR_W-1:0] addr_prev_reg;
  pend_t             wr_slot_reg;
  logic              rd_valid_reg;
  logic [ADDR_W-1:0] rd_addr_reg;

  logic              rd_det;
  logic              wr_det;
  pend_t             wr_sel;
  logic              rd_sel_valid;
  logic [ADDR_W-1:0] rd_sel_addr;

  // Previous-cycle copies of the request levels; kept running through reset
  // so a level held across reset is not mistaken for a new edge afterwards.
  always_ff @(posedge clk) begin
    oe_prev_reg   <= mem_oe;
    we_prev_reg   <= mem_we_lo | mem_we_hi;
    addr_prev_reg <= mem_addr;
  end

  assign rd_det = mem_oe && (!oe_prev_reg || (mem_addr != addr_prev_reg));
  assign wr_det = (mem_we_lo | mem_we_hi) && !we_prev_reg;

  // Newest request wins over whatever is already parked in each slot.
  always_comb begin
    wr_sel = wr_slot_reg;
    if (wr_det) begin
      wr_sel.addr  = ADDR_W_DEF'(mem_addr);
      wr_sel.data  = mem_din;
      wr_sel.mask  = {mem_we_hi, mem_we_lo};
      wr_sel.valid = 1'b1;
    end
    rd_sel_valid = rd_valid_reg | rd_det;
    rd_sel_addr  = rd_det ? mem_addr : rd_addr_reg;
  end

  // Cycle sequencer: slots, state, counter and all registered SRAM strobes.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= IDLE;
      cnt_reg      <= '0;
      wr_slot_reg  <= '0;
      rd_valid_reg <= 1'b0;
      rd_addr_reg  <= '0;
      mem_dout     <= 16'h0000;
      busy         <= 1'b0;
      sram_addr    <= '0;
      sram_dq_o    <= 16'h0000;
      sram_dq_oe   <= 1'b0;
      sram_ce_n    <= 1'b1;
      sram_oe_n    <= 1'b1;
      sram_we_n    <= 1'b1;
      sram_lb_n    <= 1'b1;
      sram_ub_n    <= 1'b1;
    end else begin
      wr_slot_reg  <= wr_sel;
      rd_valid_reg <= rd_sel_valid;
      rd_addr_reg  <= rd_sel_addr;
      case (state_reg)
        // Recovery doubles as the dispatch point, so a queued request starts
        // right after REC instead of idling one more cycle.
        IDLE, REC: begin
          if (wr_sel.valid) begin
            state_reg         <= WR;
            cnt_reg           <= WR_LOAD;
            busy              <= 1'b1;
            wr_slot_reg.valid <= 1'b0;
            sram_addr         <= ADDR_W'(wr_sel.addr);
            sram_dq_o         <= wr_sel.data;
            sram_dq_oe        <= 1'b1;
            sram_ce_n         <= 1'b0;
            sram_oe_n         <= 1'b1;
            sram_we_n         <= 1'b1;
            sram_lb_n         <= ~wr_sel.mask[0];
            sram_ub_n         <= ~wr_sel.mask[1];
          end else if (rd_sel_valid) begin
            state_reg    <= RD;
            cnt_reg      <= RD_LOAD;
            busy         <= 1'b1;
            rd_valid_reg <= 1'b0;
            sram_addr    <= rd_sel_addr;
            sram_dq_oe   <= 1'b0;
            sram_ce_n    <= 1'b0;
            sram_oe_n    <= 1'b0;
            sram_we_n    <= 1'b1;
            sram_lb_n    <= 1'b0;
            sram_ub_n    <= 1'b0;
          end else begin
            state_reg <= IDLE;
            busy      <= 1'b0;
          end
        end
        RD: begin
          if (cnt_reg == '0) begin
            mem_dout  <= sram_dq_i;
            state_reg <= REC;
            sram_ce_n <= 1'b1;
            sram_oe_n <= 1'b1;
            sram_lb_n <= 1'b1;
            sram_ub_n <= 1'b1;
          end else begin
            cnt_reg <= cnt_reg - 1'b1;
          end
        end
        WR: begin
          if (cnt_reg == '0) begin
            state_reg  <= REC;
            sram_dq_oe <= 1'b0;
            sram_ce_n  <= 1'b1;
            sram_we_n  <= 1'b1;
            sram_lb_n  <= 1'b1;
            sram_ub_n  <= 1'b1;
          end else begin
            cnt_reg <= cnt_reg - 1'b1;
            // we_n is low for every write cycle except the first and last.
            sram_we_n <= !(cnt_reg > CW'(1));
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bram_mem_rsp.sv
// Self-checking bench for bram_mem_rsp with a behavioural SRAM and a
// word-level reference model of memory contents and cycle timing.
module tb_bram_mem_rsp;

  localparam int ADDR_W = 18;
  localparam int RD_CYC = 4;
  localparam int WR_CYC = 4;

  logic              clk;
  logic              rst;
  logic [ADDR_W-1:0] mem_addr;
  logic [15:0]       mem_din;
  logic              mem_oe;
  logic              mem_we_lo;
  logic              mem_we_hi;
  logic [15:0]       mem_dout;
  logic              busy;
  logic [ADDR_W-1:0] sram_addr;
  logic [15:0]       sram_dq_o;
  logic              sram_dq_oe;
  logic [15:0]       sram_dq_i;
  logic              sram_ce_n;
  logic              sram_oe_n;
  logic              sram_we_n;
  logic              sram_lb_n;
  logic              sram_ub_n;

  int checks = 0;
  int errors = 0;

  bram_mem_rsp #(.ADDR_W(ADDR_W), .RD_CYC(RD_CYC), .WR_CYC(WR_CYC)) dut (
    .clk(clk), .rst(rst),
    .mem_addr(mem_addr), .mem_din(mem_din), .mem_oe(mem_oe),
    .mem_we_lo(mem_we_lo), .mem_we_hi(mem_we_hi),
    .mem_dout(mem_dout), .busy(busy),
    .sram_addr(sram_addr), .sram_dq_o(sram_dq_o), .sram_dq_oe(sram_dq_oe),
    .sram_dq_i(sram_dq_i),
    .sram_ce_n(sram_ce_n), .sram_oe_n(sram_oe_n), .sram_we_n(sram_we_n),
    .sram_lb_n(sram_lb_n), .sram_ub_n(sram_ub_n)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural SRAM: 1K words aliased on the low address bits, with a
  // backdoor port for preloading.
  logic [15:0] sram_arr [0:1023];
  logic        bd_we;
  logic [9:0]  bd_addr;
  logic [15:0] bd_data;

  always @(posedge clk) begin
    if (bd_we) begin
      sram_arr[bd_addr] <= bd_data;
    end else if (!sram_ce_n && !sram_we_n && sram_dq_oe) begin
      if (!sram_lb_n) sram_arr[sram_addr[9:0]][7:0]  <= sram_dq_o[7:0];
      if (!sram_ub_n) sram_arr[sram_addr[9:0]][15:8] <= sram_dq_o[15:8];
    end
  end

  assign sram_dq_i = (!sram_ce_n && !sram_oe_n) ? sram_arr[sram_addr[9:0]] : 16'hDEAD;

  // Reference model: expected SRAM contents and expected mem_dout.
  logic [15:0] ref_mem [0:1023];
  logic [15:0] exp_dout;

  // Observed strobe vector {ce_n, oe_n, we_n, lb_n, ub_n, dq_oe, busy}.
  logic [6:0] obs_vec;
  assign obs_vec = {sram_ce_n, sram_oe_n, sram_we_n, sram_lb_n, sram_ub_n, sram_dq_oe, busy};

  // Expected strobes for cycle k after a read request was accepted.
  function automatic logic [6:0] rd_vec(input int k);
    if (k <= RD_CYC) return 7'b0010001;
    else if (k == RD_CYC + 1) return 7'b1111101;
    else return 7'b1111100;
  endfunction

  // Expected strobes for cycle k after a write request was accepted.
  function automatic logic [6:0] wr_vec(input int k, input logic [1:0] m);
    logic we_n;
    we_n = (k >= 2 && k <= WR_CYC - 1) ? 1'b0 : 1'b1;
    if (k <= WR_CYC) return {1'b0, 1'b1, we_n, ~m[0], ~m[1], 1'b1, 1'b1};
    else if (k == WR_CYC + 1) return 7'b1111101;
    else return 7'b1111100;
  endfunction

  function automatic logic [15:0] merge(input logic [15:0] old, input logic [15:0] d,
                                        input logic [1:0] m);
    logic [15:0] r;
    r = old;
    if (m[0]) r[7:0] = d[7:0];
    if (m[1]) r[15:8] = d[15:8];
    return r;
  endfunction

  task automatic preload(input logic [9:0] a, input logic [15:0] d);
    @(negedge clk);
    bd_we = 1'b1; bd_addr = a; bd_data = d;
    @(negedge clk);
    bd_we = 1'b0;
    ref_mem[a] = d;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (obs_vec !== 7'b1111100) begin
      errors++; $display("FAIL reset_strobes got=%b exp=%b", obs_vec, 7'b1111100);
    end
    checks++;
    if (mem_dout !== 16'h0000) begin
      errors++; $display("FAIL reset_dout got=%h exp=0000", mem_dout);
    end
    checks++;
    if (sram_addr !== '0 || sram_dq_o !== 16'h0000) begin
      errors++; $display("FAIL reset_bus got addr=%h dq=%h exp 0/0", sram_addr, sram_dq_o);
    end
    @(negedge clk);
    rst = 1'b0;
    exp_dout = 16'h0000;
    @(posedge clk); #1;
    checks++;
    if (obs_vec !== 7'b1111100) begin
      errors++; $display("FAIL post_reset_idle got=%b exp=%b", obs_vec, 7'b1111100);
    end
    $display("txn reset");
  endtask

  task automatic test_read();
    preload(10'h345, 16'hBEEF);
    @(negedge clk);
    mem_addr = 18'h12345; mem_oe = 1'b1;
    for (int k = 1; k <= RD_CYC + 2; k++) begin
      @(posedge clk); #1;
      if (k == RD_CYC + 1) exp_dout = ref_mem[10'h345];
      checks++;
      if (obs_vec !== rd_vec(k)) begin
        errors++; $display("FAIL read_strobes k=%0d got=%b exp=%b", k, obs_vec, rd_vec(k));
      end
      checks++;
      if (mem_dout !== exp_dout) begin
        errors++; $display("FAIL read_dout k=%0d got=%h exp=%h", k, mem_dout, exp_dout);
      end
      if (k <= RD_CYC) begin
        checks++;
        if (sram_addr !== 18'h12345) begin
          errors++; $display("FAIL read_addr k=%0d got=%h exp=12345", k, sram_addr);
        end
      end
      @(negedge clk);
      if (k == 1) mem_oe = 1'b0;
    end
    $display("txn read addr=12345 dout=%h", mem_dout);
  endtask

  task automatic test_write_lo();
    preload(10'h010, 16'hFFFF);
    @(negedge clk);
    mem_addr = 18'h00010; mem_din = 16'hA55A; mem_we_lo = 1'b1;
    ref_mem[10'h010] = merge(ref_mem[10'h010], 16'hA55A, 2'b01);
    for (int k = 1; k <= WR_CYC + 2; k++) begin
      @(posedge clk); #1;
      checks++;
      if (obs_vec !== wr_vec(k, 2'b01)) begin
        errors++; $display("FAIL write_lo_strobes k=%0d got=%b exp=%b", k, obs_vec, wr_vec(k, 2'b01));
      end
      if (k <= WR_CYC) begin
        checks++;
        if (sram_addr !== 18'h00010 || sram_dq_o !== 16'hA55A) begin
          errors++; $display("FAIL write_lo_bus k=%0d got addr=%h dq=%h exp 00010/a55a", k, sram_addr, sram_dq_o);
        end
      end
      checks++;
      if (mem_dout !== exp_dout) begin
        errors++; $display("FAIL write_lo_dout_hold k=%0d got=%h exp=%h", k, mem_dout, exp_dout);
      end
      @(negedge clk);
      if (k == 1) mem_we_lo = 1'b0;
    end
    $display("txn write_lo addr=00010 data=a55a");
  endtask

  task automatic test_collision();
    logic [15:0] d;
    d = 16'($urandom);
    preload(10'h020, 16'($urandom));
    @(negedge clk);
    mem_addr = 18'h00020; mem_din = d; mem_we_hi = 1'b1; mem_oe = 1'b1;
    ref_mem[10'h020] = merge(ref_mem[10'h020], d, 2'b10);
    for (int k = 1; k <= WR_CYC + RD_CYC + 3; k++) begin
      logic [6:0] ev;
      @(posedge clk); #1;
      ev = (k <= WR_CYC + 1) ? wr_vec(k, 2'b10) : rd_vec(k - WR_CYC - 1);
      if (k == WR_CYC + RD_CYC + 2) exp_dout = ref_mem[10'h020];
      checks++;
      if (obs_vec !== ev) begin
        errors++; $display("FAIL collision_strobes k=%0d got=%b exp=%b", k, obs_vec, ev);
      end
      checks++;
      if (mem_dout !== exp_dout) begin
        errors++; $display("FAIL collision_dout k=%0d got=%h exp=%h", k, mem_dout, exp_dout);
      end
      if (k <= WR_CYC || (k > WR_CYC + 1 && k <= WR_CYC + RD_CYC + 1)) begin
        checks++;
        if (sram_addr !== 18'h00020) begin
          errors++; $display("FAIL collision_addr k=%0d got=%h exp=00020", k, sram_addr);
        end
      end
      @(negedge clk);
      if (k == 1) begin
        mem_we_hi = 1'b0; mem_oe = 1'b0;
      end
    end
    $display("txn collision addr=00020 data=%h dout=%h", d, mem_dout);
  endtask

  task automatic test_held_oe();
    preload(10'h001, 16'($urandom));
    preload(10'h002, 16'($urandom));
    @(negedge clk);
    mem_addr = 18'h00001; mem_oe = 1'b1;
    for (int k = 1; k <= 2 * RD_CYC + 3; k++) begin
      logic [6:0] ev;
      @(posedge clk); #1;
      ev = (k <= RD_CYC + 1) ? rd_vec(k) : rd_vec(k - RD_CYC - 1);
      if (k == RD_CYC + 1) exp_dout = ref_mem[10'h001];
      if (k == 2 * RD_CYC + 2) exp_dout = ref_mem[10'h002];
      checks++;
      if (obs_vec !== ev) begin
        errors++; $display("FAIL held_oe_strobes k=%0d got=%b exp=%b", k, obs_vec, ev);
      end
      checks++;
      if (mem_dout !== exp_dout) begin
        errors++; $display("FAIL held_oe_dout k=%0d got=%h exp=%h", k, mem_dout, exp_dout);
      end
      if (k <= RD_CYC) begin
        checks++;
        if (sram_addr !== 18'h00001) begin
          errors++; $display("FAIL held_oe_addr1 k=%0d got=%h exp=00001", k, sram_addr);
        end
      end else if (k > RD_CYC + 1 && k <= 2 * RD_CYC + 1) begin
        checks++;
        if (sram_addr !== 18'h00002) begin
          errors++; $display("FAIL held_oe_addr2 k=%0d got=%h exp=00002", k, sram_addr);
        end
      end
      @(negedge clk);
      if (k == 2) mem_addr = 18'h00002;
    end
    mem_oe = 1'b0;
    $display("txn held_oe addr=00001,00002 dout=%h", mem_dout);
  endtask

  task automatic test_random();
    for (int a = 0; a < 64; a++) preload(10'(a), 16'($urandom));
    for (int it = 0; it < 24; it++) begin
      int          op;
      int          len;
      logic [9:0]  a;
      logic [15:0] d;
      logic [1:0]  m;
      op  = int'($urandom_range(0, 3));
      a   = 10'($urandom_range(0, 63));
      d   = 16'($urandom);
      m   = 2'(op);
      len = (op == 0) ? RD_CYC : WR_CYC;
      @(negedge clk);
      mem_addr = ADDR_W'(a);
      if (op == 0) begin
        mem_oe = 1'b1;
      end else begin
        mem_din = d; mem_we_lo = m[0]; mem_we_hi = m[1];
        ref_mem[a] = merge(ref_mem[a], d, m);
      end
      for (int k = 1; k <= len + 2; k++) begin
        logic [6:0] ev;
        @(posedge clk); #1;
        ev = (op == 0) ? rd_vec(k) : wr_vec(k, m);
        if (op == 0 && k == RD_CYC + 1) exp_dout = ref_mem[a];
        checks++;
        if (obs_vec !== ev) begin
          errors++; $display("FAIL rand_strobes it=%0d k=%0d got=%b exp=%b", it, k, obs_vec, ev);
        end
        checks++;
        if (mem_dout !== exp_dout) begin
          errors++; $display("FAIL rand_dout it=%0d k=%0d got=%h exp=%h", it, k, mem_dout, exp_dout);
        end
        @(negedge clk);
        if (k == 1) begin
          mem_oe = 1'b0; mem_we_lo = 1'b0; mem_we_hi = 1'b0;
        end
      end
      $display("txn rand %0d %s addr=%h mask=%b data=%h dout=%h", it,
               (op == 0) ? "rd" : "wr", a, m, d, mem_dout);
    end
  endtask

  task automatic test_reset_mid_write();
    @(negedge clk);
    mem_addr = 18'h00300; mem_din = 16'h1234; mem_we_lo = 1'b1;
    for (int k = 1; k <= 2; k++) begin
      @(posedge clk); #1;
      checks++;
      if (obs_vec !== wr_vec(k, 2'b01)) begin
        errors++; $display("FAIL midrst_pre k=%0d got=%b exp=%b", k, obs_vec, wr_vec(k, 2'b01));
      end
    end
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    exp_dout = 16'h0000;
    checks++;
    if (obs_vec !== 7'b1111100) begin
      errors++; $display("FAIL midrst_abort got=%b exp=%b", obs_vec, 7'b1111100);
    end
    @(negedge clk);
    rst = 1'b0;
    for (int j = 0; j < 6; j++) begin
      @(posedge clk); #1;
      checks++;
      if (obs_vec !== 7'b1111100) begin
        errors++; $display("FAIL midrst_quiet j=%0d got=%b exp=%b", j, obs_vec, 7'b1111100);
      end
    end
    checks++;
    if (mem_dout !== exp_dout) begin
      errors++; $display("FAIL midrst_dout got=%h exp=%h", mem_dout, exp_dout);
    end
    @(negedge clk);
    mem_we_lo = 1'b0;
    $display("txn reset_mid_write addr=00300");
  endtask

  initial begin
    rst = 1'b1;
    mem_addr = '0; mem_din = 16'h0000;
    mem_oe = 1'b0; mem_we_lo = 1'b0; mem_we_hi = 1'b0;
    bd_we = 1'b0; bd_addr = 10'h000; bd_data = 16'h0000;
    exp_dout = 16'h0000;
    for (int i = 0; i < 1024; i++) ref_mem[i] = 16'h0000;
    test_reset();
    test_read();
    test_write_lo();
    test_collision();
    test_held_oe();
    test_random();
    test_reset_mid_write();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog timeout checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

endmodule
